// File: rtl/fx_fir_mac_multiband.sv
// Multiband sign-magnitude FIR: one tap multiply-accumulate per cycle, coefficient set chosen per sample.
// Latency TAPS+1 cycles accept->out_valid; in_ready low while busy, output strobe has no backpressure.
module fx_fir_mac_multiband #(
    parameter int DATA_W = 16,
    parameter int TAPS   = 30,
    parameter int BANDS  = 4,
    localparam int AW    = (TAPS > 1) ? $clog2(TAPS) : 1,
    localparam int BW    = (BANDS > 1) ? $clog2(BANDS) : 1,
    localparam int ACC_W = 2*DATA_W - 1 + AW
) (
    input  logic              clk_slow,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] fir_in,
    input  logic [BW-1:0]     band_sel,
    input  logic              coef_we,
    input  logic [BW-1:0]     coef_band,
    input  logic [AW-1:0]     coef_addr,
    input  logic [DATA_W-1:0] coef_data,
    output logic              out_valid,
    output logic [DATA_W-1:0] fir_out
);
    localparam int PW = 2*DATA_W - 2;
    localparam logic signed [ACC_W-1:0] SAT_MAX = ACC_W'((64'sd1 <<< (DATA_W-1)) - 64'sd1);
    localparam logic signed [ACC_W-1:0] SAT_MIN = -SAT_MAX;

    typedef enum logic [1:0] {IDLE, MAC, OUT} state_t;

    state_t                  state_q, state_d;
    logic [DATA_W-1:0]       coef_q [BANDS][TAPS];
    logic [DATA_W-1:0]       hist_q [TAPS];
    logic [BW-1:0]           band_q, band_d;
    logic [AW-1:0]           tap_q, tap_d;
    logic signed [ACC_W-1:0] acc_q, acc_d;
    logic [DATA_W-1:0]       fir_out_q, fir_out_d;

    logic                    accept, last_tap, coef_wr;
    logic [DATA_W-1:0]       c_cur, x_cur;
    logic [PW-1:0]           p_mag;
    logic signed [ACC_W-1:0] p_term, acc_sum, shifted, sat;
    logic [DATA_W-2:0]       sat_abs;

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == OUT);
    assign fir_out   = fir_out_q;
    assign accept    = in_valid && in_ready;
    assign last_tap  = (tap_q == AW'(TAPS-1));
    assign coef_wr   = coef_we && (state_q == IDLE)
                       && (32'(coef_addr) < TAPS) && (32'(coef_band) < BANDS);

    // Datapath: sign-magnitude product folded into a two's-complement sum, then
    // floor-shift, symmetric saturation and re-encoding (zero never gets a sign bit).
    always_comb begin
        c_cur     = coef_q[band_q][tap_q];
        x_cur     = hist_q[tap_q];
        p_mag     = PW'(c_cur[DATA_W-2:0]) * PW'(x_cur[DATA_W-2:0]);
        p_term    = (c_cur[DATA_W-1] ^ x_cur[DATA_W-1]) ? -$signed(ACC_W'(p_mag))
                                                        :  $signed(ACC_W'(p_mag));
        acc_sum   = acc_q + p_term;
        shifted   = acc_sum >>> (DATA_W-1);
        if (shifted > SAT_MAX) begin
            sat = SAT_MAX;
        end else if (shifted < SAT_MIN) begin
            sat = SAT_MIN;
        end else begin
            sat = shifted;
        end
        sat_abs   = (DATA_W-1)'(sat[ACC_W-1] ? -sat : sat);
        fir_out_d = {sat[ACC_W-1], sat_abs};
    end

    always_comb begin
        state_d = state_q;
        tap_d   = tap_q;
        acc_d   = acc_q;
        band_d  = band_q;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    state_d = MAC;
                    tap_d   = '0;
                    acc_d   = '0;
                    band_d  = band_sel;
                end
            end
            MAC: begin
                acc_d = acc_sum;
                tap_d = tap_q + 1'b1;
                if (last_tap) begin
                    state_d = OUT;
                end
            end
            OUT:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_slow or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk_slow or negedge rst) begin
        if (!rst) begin
            tap_q     <= '0;
            acc_q     <= '0;
            band_q    <= '0;
            fir_out_q <= '0;
        end else begin
            tap_q  <= tap_d;
            acc_q  <= acc_d;
            band_q <= band_d;
            if (state_q == MAC && last_tap) begin
                fir_out_q <= fir_out_d;
            end
        end
    end

    // History is shared by all bands; a coefficient write may land in the same
    // cycle as an accept and is already visible to that sample's first tap.
    always_ff @(posedge clk_slow or negedge rst) begin
        if (!rst) begin
            for (int k = 0; k < TAPS; k++) begin
                hist_q[k] <= '0;
            end
            for (int b = 0; b < BANDS; b++) begin
                for (int k = 0; k < TAPS; k++) begin
                    coef_q[b][k] <= '0;
                end
            end
        end else begin
            if (accept) begin
                hist_q[0] <= fir_in;
                for (int k = 1; k < TAPS; k++) begin
                    hist_q[k] <= hist_q[k-1];
                end
            end
            if (coef_wr) begin
                coef_q[coef_band][coef_addr] <= coef_data;
            end
        end
    end
endmodule

// File: tb/tb_fx_fir_mac_multiband.sv
// Bench for fx_fir_mac_multiband: directed and random samples against an integer-arithmetic FIR model.
module tb_fx_fir_mac_multiband;
    localparam int DATA_W = 16;
    localparam int TAPS   = 30;
    localparam int BANDS  = 4;

    logic        clk_slow = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] fir_in;
    logic [1:0]  band_sel;
    logic        coef_we;
    logic [1:0]  coef_band;
    logic [4:0]  coef_addr;
    logic [15:0] coef_data;
    logic        out_valid;
    logic [15:0] fir_out;

    int checks = 0;
    int errors = 0;

    logic [15:0] mcoef [BANDS][TAPS];
    logic [15:0] mh [TAPS];

    always #5 clk_slow = ~clk_slow;

    fx_fir_mac_multiband #(.DATA_W(DATA_W), .TAPS(TAPS), .BANDS(BANDS)) dut (
        .clk_slow  (clk_slow),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .fir_in    (fir_in),
        .band_sel  (band_sel),
        .coef_we   (coef_we),
        .coef_band (coef_band),
        .coef_addr (coef_addr),
        .coef_data (coef_data),
        .out_valid (out_valid),
        .fir_out   (fir_out)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        checks++;
        assert (obs === exp_v) else begin
            errors++;
            $error("FAIL %s observed %h expected %h", tag, obs, exp_v);
        end
    endtask

    function automatic longint sm2int(input logic [15:0] v);
        longint mag;
        mag = longint'(v[14:0]);
        return v[15] ? -mag : mag;
    endfunction

    function automatic logic [15:0] ref_out(input logic [1:0] b);
        longint acc, q;
        acc = 0;
        for (int k = 0; k < TAPS; k++) acc += sm2int(mcoef[b][k]) * sm2int(mh[k]);
        q = acc >>> 15;
        if (q > 32767)  q = 32767;
        if (q < -32767) q = -32767;
        if (q < 0) return {1'b1, 15'(-q)};
        return 16'(q);
    endfunction

    task automatic model_push(input logic [15:0] s);
        for (int k = TAPS-1; k > 0; k--) mh[k] = mh[k-1];
        mh[0] = s;
    endtask

    task automatic model_clear();
        for (int k = 0; k < TAPS; k++) begin
            mh[k] = '0;
            for (int b = 0; b < BANDS; b++) mcoef[b][k] = '0;
        end
    endtask

    task automatic write_coef(input logic [1:0] b, input logic [4:0] a, input logic [15:0] d);
        coef_we = 1'b1; coef_band = b; coef_addr = a; coef_data = d;
        if (a < TAPS) mcoef[b][a] = d;
        @(negedge clk_slow);
        coef_we = 1'b0;
    endtask

    // Offers one sample (optionally with a same-cycle coefficient write), optionally
    // hammers coef_we during MAC, and checks latency, value, strobe width and hold.
    task automatic do_sample(input logic [15:0] s, input logic [1:0] b, input bit cw,
                             input logic [1:0] cb, input logic [4:0] ca, input logic [15:0] cd,
                             input bit mac_we, output logic [15:0] obs);
        int n;
        logic [15:0] exp_v;
        n = 0;
        while (!in_ready && n < 64) begin @(negedge clk_slow); n++; end
        check("ready_before_accept", 32'(in_ready), 1);
        in_valid = 1'b1; fir_in = s; band_sel = b;
        coef_we = cw; coef_band = cb; coef_addr = ca; coef_data = cd;
        if (cw && ca < TAPS) mcoef[cb][ca] = cd;
        model_push(s);
        exp_v = ref_out(b);
        @(negedge clk_slow);
        in_valid = 1'b0; fir_in = 16'($urandom); band_sel = ~b;
        coef_we = mac_we; coef_band = b; coef_addr = '0; coef_data = 16'h7FFF;
        n = 1;
        while (!out_valid && n < 40) begin @(negedge clk_slow); n++; end
        coef_we = 1'b0;
        obs = fir_out;
        check("latency", n, 31);
        check("fir_out", 32'(fir_out), 32'(exp_v));
        check("busy_in_out", 32'(in_ready), 0);
        @(negedge clk_slow);
        check("valid_one_cycle", 32'(out_valid), 0);
        check("fir_out_hold", 32'(fir_out), 32'(exp_v));
    endtask

    initial begin
        logic [15:0] obs;
        int nrdy, nval, first, second, first_out;
        rst = 1'b0; in_valid = 1'b0; fir_in = '0; band_sel = '0;
        coef_we = 1'b0; coef_band = '0; coef_addr = '0; coef_data = '0;
        model_clear();
        repeat (2) @(negedge clk_slow);
        check("rst_in_ready", 32'(in_ready), 1);
        check("rst_out_valid", 32'(out_valid), 0);
        check("rst_fir_out", 32'(fir_out), 0);
        rst = 1'b1;
        @(negedge clk_slow);
        check("post_rst_in_ready", 32'(in_ready), 1);

        // Impulse through tap 3
        write_coef(2'd0, 5'd3, 16'h0080);
        do_sample(16'h4000, 2'd0, 1'b0, 2'd0, 5'd0, 16'h0, 1'b0, obs);
        check("impulse_out1", 32'(obs), 32'h0000);
        for (int i = 0; i < 3; i++) do_sample(16'h0000, 2'd0, 1'b0, 2'd0, 5'd0, 16'h0, 1'b0, obs);
        check("impulse_out4", 32'(obs), 32'h0040);
        do_sample(16'h0000, 2'd0, 1'b0, 2'd0, 5'd0, 16'h0, 1'b0, obs);
        check("impulse_out5", 32'(obs), 32'h0000);

        // Sign handling and negative zero
        write_coef(2'd0, 5'd3, 16'h0000);
        write_coef(2'd0, 5'd0, 16'hC000);
        write_coef(2'd0, 5'd31, 16'h7FFF);
        do_sample(16'h4000, 2'd0, 1'b0, 2'd0, 5'd0, 16'h0, 1'b0, obs);
        check("sign_neg", 32'(obs), 32'hA000);
        do_sample(16'h8000, 2'd0, 1'b0, 2'd0, 5'd0, 16'h0, 1'b0, obs);
        check("neg_zero", 32'(obs), 32'h0000);

        // Saturation in band 1
        for (int k = 0; k < TAPS; k++) write_coef(2'd1, 5'(k), 16'h7FFF);
        for (int i = 0; i < TAPS; i++) do_sample(16'h7FFF, 2'd1, 1'b0, 2'd0, 5'd0, 16'h0, 1'b0, obs);
        check("sat_pos", 32'(obs), 32'h7FFF);
        for (int i = 0; i < TAPS; i++) do_sample(16'hFFFF, 2'd1, 1'b0, 2'd0, 5'd0, 16'h0, 1'b0, obs);
        check("sat_neg", 32'(obs), 32'hFFFF);

        // Same-cycle write+accept, and a write attempted throughout MAC
        do_sample(16'h2000, 2'd1, 1'b1, 2'd1, 5'd0, 16'h8123, 1'b0, obs);
        do_sample(16'h1000, 2'd1, 1'b0, 2'd0, 5'd0, 16'h0, 1'b1, obs);
        do_sample(16'h1000, 2'd1, 1'b0, 2'd0, 5'd0, 16'h0, 1'b0, obs);

        // Random band switching between bands 0 and 2
        for (int k = 0; k < TAPS; k++) begin
            write_coef(2'd0, 5'(k), 16'($urandom));
            write_coef(2'd2, 5'(k), 16'($urandom));
        end
        for (int i = 0; i < 200; i++) begin
            do_sample(16'($urandom), (i % 2 == 0) ? 2'd0 : 2'd2,
                      ($urandom_range(0, 7) == 0), ($urandom_range(0, 1) == 0) ? 2'd0 : 2'd2,
                      5'($urandom_range(0, 31)), 16'($urandom),
                      ($urandom_range(0, 3) == 0), obs);
        end

        // in_valid held high: accept period and output spacing
        fir_in = '0; band_sel = '0; in_valid = 1'b1;
        nrdy = 0; nval = 0; first = -1; second = -1; first_out = -1;
        for (int i = 0; i < 96; i++) begin
            if (in_ready) begin
                model_push(16'h0000);
                nrdy++;
                if (first < 0) first = i;
                else if (second < 0) second = i;
            end
            if (out_valid) begin
                nval++;
                if (first_out < 0) first_out = i;
            end
            @(negedge clk_slow);
        end
        in_valid = 1'b0;
        check("ready_count", nrdy, 3);
        check("ready_period", second - first, 32);
        check("valid_count", nval, 3);
        check("accept_to_valid", first_out - first, 31);

        // Reset at cycle 10 of MAC
        in_valid = 1'b1; fir_in = 16'h1234; band_sel = 2'd0;
        @(negedge clk_slow);
        in_valid = 1'b0;
        repeat (9) @(negedge clk_slow);
        rst = 1'b0;
        #1;
        check("midrst_in_ready", 32'(in_ready), 1);
        check("midrst_out_valid", 32'(out_valid), 0);
        check("midrst_fir_out", 32'(fir_out), 0);
        @(negedge clk_slow);
        rst = 1'b1;
        model_clear();
        nval = 0;
        repeat (40) begin
            @(negedge clk_slow);
            if (out_valid) nval++;
        end
        check("midrst_no_valid", nval, 0);
        do_sample(16'h7FFF, 2'd0, 1'b0, 2'd0, 5'd0, 16'h0, 1'b0, obs);
        check("after_rst_zero", 32'(obs), 32'h0000);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
